mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_pkg.sv | 20 ++
 rtl/bus_watchdog.sv | 37 +++
 rtl/mem_sequencer.sv | 129 ++++++++++++
 tb/tb_mem_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared types and constants for the memory sequencer.
// State encoding and the NOP word loaded into instr on reset.
package mem_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    DATA,
    COMMIT,
    ERROR
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic is_bus_state(state_e s);
    return (s == FETCH) || (s == DATA);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus wait-cycle counter; raises expire_o on the wait cycle
// that brings the count up to Limit.
module bus_watchdog #(
  parameter int Limit = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam int W = $clog2(Limit + 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = wait_i & ~clear_i
                  & ((int'(cnt_q) + 1) >= Limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle fetch/execute/data sequencer on a valid/ready bus.
// Define MEM_SEQUENCER_TIMEOUT_EN to add the bus wait timeout.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic        misaligned_addr,
  output logic [31:0] d_rdata,
  output logic        halted,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  output logic        bus_error
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] d_rdata_q;
  logic        halted_q;
  logic        bus_valid_q;
  logic        hs;
  logic        expire;
  logic        mem_op;

  assign hs     = bus_valid_q & bus_ready;
  assign mem_op = (d_rd | d_wr) & ~misaligned_addr;

`ifdef MEM_SEQUENCER_TIMEOUT_EN
  logic bus_error_q;

  bus_watchdog #(
    .Limit(TimeoutCycles)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (~bus_valid_q),
    .wait_i  (bus_valid_q & ~bus_ready),
    .expire_o(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error_q <= 1'b0;
    end else if (expire && !bus_ready) begin
      bus_error_q <= 1'b1;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign expire    = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (hs) state_d = EXEC;
        else if (expire) state_d = ERROR;
      end
      EXEC:   state_d = mem_op ? DATA : COMMIT;
      DATA: begin
        if (hs) state_d = COMMIT;
        else if (expire) state_d = ERROR;
      end
      COMMIT: state_d = FETCH;
      ERROR:  state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      instr_q     <= NOP;
      d_rdata_q   <= '0;
      halted_q    <= 1'b1;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted_q    <= (state_d != COMMIT);
      bus_valid_q <= is_bus_state(state_d);
      if (hs && state_q == FETCH) instr_q <= bus_rdata;
      if (hs && state_q == DATA) d_rdata_q <= bus_rdata;
    end
  end

  // Address/data follow the frozen datapath inputs, stable while halted.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    unique case (1'b1)
      (state_q == FETCH): begin
        bus_addr = pc;
      end
      (state_q == DATA): begin
        bus_addr  = {d_addr[31:2], 2'b00};
        bus_wdata = d_wdata;
        bus_wstrb = d_wr ? d_be : 4'b0000;
      end
      default: ;
    endcase
  end

  assign instr     = instr_q;
  assign d_rdata   = d_rdata_q;
  assign halted    = halted_q;
  assign bus_valid = bus_valid_q;

  logic unused;
  assign unused = ^{d_addr[1:0], (TimeoutCycles > 0)};

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized self-checking bench for mem_sequencer.
// Acts as both datapath and bus slave around the sequencer.
module tb_mem_sequencer;

`ifdef MEM_SEQUENCER_TIMEOUT_EN
  localparam int TO = 4;
  localparam int LW = 3;
  localparam int RW = 2;
`else
  localparam int TO = 255;
  localparam int LW = 5;
  localparam int RW = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instr, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, bus_wstrb;
  logic        d_rd, d_wr, misaligned_addr;
  logic        halted, bus_valid, bus_ready, bus_error;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_instr;
  logic [31:0] m_drdata;

  mem_sequencer #(.TimeoutCycles(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instr          (instr),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_be           (d_be),
    .d_rd           (d_rd),
    .d_wr           (d_wr),
    .misaligned_addr(misaligned_addr),
    .d_rdata        (d_rdata),
    .halted         (halted),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_rdata      (bus_rdata),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check_reset_outs(input string nm);
    checks++;
    if (instr !== 32'h13 || d_rdata !== 32'h0 || halted !== 1'b1
        || bus_valid !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL %s: instr=%h d_rdata=%h halted=%b valid=%b err=%b, want 00000013 0 1 0 0",
               nm, instr, d_rdata, halted, bus_valid, bus_error);
    end
  endtask

  // One instruction; returns at the negedge where halted is observed low.
  task automatic run_instr(input logic [31:0] p, input logic rd, input logic wr,
                           input logic mis, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int wf, input int wdw,
                           input logic [31:0] rf, input logic [31:0] rdv,
                           input string nm);
    int cyc, ntx, w, exp_cyc, exp_tx;
    bit done, bad;
    logic mem;
    logic [31:0] ea;
    logic [3:0] es;
    mem = (rd | wr) & ~mis;
    pc = p; d_rd = rd; d_wr = wr; misaligned_addr = mis;
    d_addr = a; d_wdata = wd; d_be = be; bus_ready = 1'b0;
    cyc = 0; ntx = 0; w = 0; done = 0; bad = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus_ready = 1'b0;
      if (!halted) begin
        done = 1;
        if (bus_valid !== 1'b0) bad = 1;
      end else if (bus_valid) begin
        ea = (ntx == 0) ? p : {a[31:2], 2'b00};
        es = (ntx == 0 || !wr) ? 4'b0000 : be;
        if (bus_addr !== ea || bus_wstrb !== es) bad = 1;
        if (ntx > 0 && bus_wdata !== wd) bad = 1;
        if (w == ((ntx == 0) ? wf : wdw)) begin
          bus_ready = 1'b1;
          bus_rdata = (ntx == 0) ? rf : rdv;
          ntx++;
          w = 0;
        end else begin
          w++;
          bus_rdata = $urandom;
        end
      end else begin
        if (bus_wstrb !== 4'b0000) bad = 1;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
    bus_ready = 1'b0;
    m_instr = rf;
    if (mem) m_drdata = rdv;
    exp_cyc = 3 + wf + (mem ? 1 + wdw : 0);
    exp_tx  = mem ? 2 : 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s bus: wrong addr/wstrb/wdata/valid seen, want addr=%h wstrb=%b",
               nm, {a[31:2], 2'b00}, wr ? be : 4'b0);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", nm, cyc, exp_cyc);
    end
    checks++;
    if (ntx !== exp_tx) begin
      errors++;
      $display("FAIL %s transfers: got %0d, want %0d", nm, ntx, exp_tx);
    end
    checks++;
    if (instr !== m_instr || d_rdata !== m_drdata) begin
      errors++;
      $display("FAIL %s latch: instr=%h d_rdata=%h, want %h %h",
               nm, instr, d_rdata, m_instr, m_drdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc = 32'h0; d_addr = 0; d_wdata = 0; d_be = 0;
    d_rd = 0; d_wr = 0; misaligned_addr = 0;
    bus_ready = 1'b0; bus_rdata = 0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    m_instr = 32'h13;
    m_drdata = 32'h0;
    reset = 1'b1;
  endtask

  task automatic test_addi();
    run_instr(32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0,
              32'h0010_0093, 32'h0, "addi");
  endtask

  task automatic test_store();
    run_instr(32'h4, 0, 1, 0, 32'h1006, 32'hAABB_0000, 4'b1100, 0, 0,
              32'h00A1_2223, 32'h1234_5678, "store");
  endtask

  task automatic test_load_wait();
    run_instr(32'h8, 1, 0, 0, 32'h2000, 32'h0, 4'hF, 1, LW,
              32'h0000_2083, 32'hCAFE_F00D, "load_wait");
  endtask

  task automatic test_misaligned();
    run_instr(32'hC, 0, 1, 1, 32'h3001, 32'h5555_5555, 4'b0011, 0, 0,
              32'h0011_10A3, 32'hDEAD_BEEF, "misaligned");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), $urandom, $urandom,
                4'($urandom), $urandom_range(0, RW), $urandom_range(0, RW),
                $urandom, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid();
    int cyc, ntx;
    bit hit;
    pc = 32'h100; d_rd = 1; d_wr = 0; misaligned_addr = 0;
    d_addr = 32'h4000; d_be = 4'hF; d_wdata = 0;
    cyc = 0; ntx = 0; hit = 0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bus_ready = 1'b0;
      if (bus_valid && ntx == 0) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0001;
        ntx = 1;
      end else if (bus_valid && bus_addr == 32'h4000) begin
        hit = (cyc > 3);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid: DATA wait not reached within %0d cycles", cyc);
    end
    #2 reset = 1'b0;
    #1 check_reset_outs("reset_mid_async");
    m_instr = 32'h13;
    m_drdata = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    run_instr(32'h200, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0,
              32'h0000_0013, 32'h0, "after_reset");
  endtask

`ifdef MEM_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    int nwait;
    bit bad;
    pc = 32'h300; d_rd = 0; d_wr = 0; misaligned_addr = 0;
    bus_ready = 1'b0;
    nwait = 0; bad = 0;
    for (int i = 0; i < 30 && bus_error !== 1'b1; i++) begin
      @(negedge clk);
      if (bus_valid) nwait++;
    end
    checks++;
    if (bus_error !== 1'b1 || nwait !== TO) begin
      errors++;
      $display("FAIL timeout: err=%b after %0d wait cycles, want 1 after %0d",
               bus_error, nwait, TO);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_ready = 1'($urandom);
      if (halted !== 1'b1 || bus_valid !== 1'b0 || bus_error !== 1'b1) bad = 1;
    end
    bus_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL error_hold: halted/valid/err left 1/0/1");
    end
    reset = 1'b0;
    #1 check_reset_outs("timeout_reset");
    m_instr = 32'h13;
    m_drdata = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    run_instr(32'h400, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0,
              32'h0040_0013, 32'h0, "after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_load_wait();
    test_misaligned();
    test_random();
    test_reset_mid();
`ifdef MEM_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
